// File: rtl/song_mem_sequencer.sv
// song_mem_sequencer
//
// Drives the sample memory for record and playback. Each AC97 ready strobe
// produces at most one memory access: a write of mic_sample when recording,
// or a read into audio_out when playing back. A 16-entry table keeps the
// recorded length of each song slot. song_done pulses when playback reaches
// the recorded length or when a recording fills its slot.
//
// Slot s occupies addresses [s << SLOT_LOG2, (s+1) << SLOT_LOG2).
// ADDR_W must equal 4 + SLOT_LOG2.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   ready        1-cycle pulse per AC97 sample period
//   start_song   1-cycle pulse; latches song_choice / record_mode
//   pause_song   1 = hold; no new accesses are issued
//   record_mode  1 = record, 0 = playback
//   song_choice  slot index 0..15
//   cfsm_state   central FSM state; 2'b00 = standby (stop request)
//   mic_sample   sample to record
//   mem_rdata    read data, valid while mem_ack = 1
//   mem_ack      1-cycle pulse completing the request
//   mem_req      access request, held until mem_ack
//   mem_we       1 = write; stable while mem_req = 1
//   mem_addr     slot base + offset; stable while mem_req = 1
//   mem_wdata    sample captured at ready; stable while mem_req = 1
//   audio_out    last sample read; 0 when not playing
//   song_done    1-cycle pulse at end of song or slot full
//   overrun      sticky; ready seen while an access was outstanding
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no song active; waiting for start_song
// RUN    | song active, no access outstanding; checks stop/end/full/ready
// ACCESS | mem_req high, waiting for mem_ack
// STOP   | stop request seen; commits recorded length, then back to IDLE

module song_mem_sequencer #(
  parameter int SLOT_LOG2 = 15,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              start_song,
  input  logic              pause_song,
  input  logic              record_mode,
  input  logic [3:0]        song_choice,
  input  logic [1:0]        cfsm_state,
  input  logic [DATA_W-1:0] mic_sample,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] audio_out,
  output logic              song_done,
  output logic              overrun
);

  // One extra bit so a completely full slot (offset == 2**SLOT_LOG2) is
  // representable without wrapping back to zero.
  localparam int OFS_W = SLOT_LOG2 + 1;
  localparam logic [OFS_W-1:0] SLOT_FULL = {1'b1, {SLOT_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ACCESS,
    S_STOP
  } state_t;

  state_t           state;
  logic [3:0]       slot;
  logic             mode;
  logic [OFS_W-1:0] offset;
  logic [OFS_W-1:0] len_l;
  logic [OFS_W-1:0] len_tab [16];

  logic stop_req;
  logic slot_full;
  logic len_we;

  assign stop_req  = (cfsm_state == 2'b00);
  assign slot_full = (offset == SLOT_FULL);

  // The length table is written when a recording stops or fills its slot.
  // This is kept independent of start_song so a restart in the same cycle
  // still commits the length of the recording that just ended.
  assign len_we = mode &&
                  ((state == S_STOP) ||
                   ((state == S_RUN) && !stop_req && slot_full));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      slot      <= '0;
      mode      <= 1'b0;
      offset    <= '0;
      len_l     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      audio_out <= '0;
      song_done <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        len_tab[i] <= '0;
      end
    end else begin
      song_done <= 1'b0;

      if (len_we) begin
        len_tab[slot] <= offset;
      end

      if (start_song) begin
        // Restart from any state; an outstanding access is abandoned.
        state     <= S_RUN;
        slot      <= song_choice;
        mode      <= record_mode;
        // Bypass so a length committed this same cycle is seen.
        len_l     <= (len_we && (slot == song_choice)) ? offset
                                                       : len_tab[song_choice];
        offset    <= '0;
        mem_req   <= 1'b0;
        audio_out <= '0;
        overrun   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end

          S_RUN: begin
            if (stop_req) begin
              state <= S_STOP;
            end else if (!mode && (offset == len_l)) begin
              song_done <= 1'b1;
              audio_out <= '0;
              state     <= S_IDLE;
            end else if (mode && slot_full) begin
              song_done <= 1'b1;
              audio_out <= '0;
              state     <= S_IDLE;
            end else if (ready && !pause_song) begin
              mem_req   <= 1'b1;
              mem_we    <= mode;
              mem_addr  <= {slot, offset[SLOT_LOG2-1:0]};
              mem_wdata <= mic_sample;
              state     <= S_ACCESS;
            end
          end

          S_ACCESS: begin
            // A strobe arriving here has no slot to go into; it is dropped.
            if (ready) begin
              overrun <= 1'b1;
            end
            if (mem_ack) begin
              mem_req <= 1'b0;
              offset  <= offset + 1'b1;
              if (!mode) begin
                audio_out <= mem_rdata;
              end
              state <= stop_req ? S_STOP : S_RUN;
            end
          end

          S_STOP: begin
            audio_out <= '0;
            state     <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
